// File: rtl/mainfsm_pkg.sv
// ---------------------------------------------------------------------------
// arm_multi_defs
// Shared definitions for the multicycle ARM control unit.
//   - 4-bit main FSM state encodings (FETCH = 0 ... UNKNOWN = 10)
//   - ALUSrcA, ALUSrcB and ResultSrc mux select encodings
//   - ctrl_t: packed control vector, MSB first in the order
//     NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc,
//     ALUSrcA, ALUSrcB, ALUOp (13 bits total)
// ---------------------------------------------------------------------------
package arm_multi_defs;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_UNKNOWN  = 4'd10;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       mem_w;
        logic       reg_w;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_if.sv
// ---------------------------------------------------------------------------
// mainfsm_if
// Bundles the instruction fields driven into the main FSM and the control
// requests it produces, for blocks that want to pass them around as a group.
//   master: drives Op/Funct, observes the control requests (decoder side)
//   slave : consumes Op/Funct, drives the control requests (FSM side)
// ---------------------------------------------------------------------------
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;

    modport master (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );

    modport slave (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );
endinterface

// File: rtl/mainfsm.sv
// ---------------------------------------------------------------------------
// mainfsm
// Moore FSM sequencing the multicycle ARM datapath through fetch, decode,
// execute, memory and writeback. Enables are unconditioned requests; the
// conditional logic downstream gates RegW/MemW/Branch/NextPC.
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous active-high, forces FETCH
//   Op        in  2  Instr[27:26]
//   Funct     in  6  Instr[25:20] (bit 5 = immediate, bit 0 = load)
//   IRWrite   out 1  load instruction register
//   AdrSrc    out 1  memory address select (0 PC, 1 Result)
//   ALUSrcA   out 2  ALU A select
//   ALUSrcB   out 2  ALU B select
//   ResultSrc out 2  result select
//   ALUOp     out 1  1 = decoder picks ALU function, 0 = add
//   NextPC    out 1  PC <= PC+4 request
//   RegW      out 1  register write request
//   MemW      out 1  memory write request
//   Branch    out 1  branch-target PC load request
// ---------------------------------------------------------------------------
module mainfsm
    import arm_multi_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch
);

    logic [3:0] state;
    logic [3:0] next_state;
    ctrl_t      ctrl;

    // Only the I and L bits of Funct steer sequencing; the rest belong to
    // the instruction decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Op is looked at only in DECODE and Funct only in DECODE/MEMADR, so
    // the instruction fields may change freely in every other state.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   next_state = S_MEMADR;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_UNKNOWN;
                endcase
            end
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_MEMADR:   next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    next_state = S_MEMWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Output decode. Unencoded states and UNKNOWN fall through to the
    // all-zero vector so they have no architectural effect.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.next_pc    = 1'b1;
                ctrl.ir_write   = 1'b1;
                ctrl.result_src = RES_ALURESULT;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.result_src = RES_ALURESULT;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_WD;
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_DATA;
            end
            S_MEMWR: begin
                ctrl.mem_w      = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.result_src = RES_ALURESULT;
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
            end
            default: ctrl = '0;
        endcase
    end

    assign NextPC    = ctrl.next_pc;
    assign Branch    = ctrl.branch;
    assign MemW      = ctrl.mem_w;
    assign RegW      = ctrl.reg_w;
    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;

endmodule

// File: doc/mainfsm.md
# mainfsm

Moore state machine sequencing the multicycle ARM datapath, one instruction at a time. Sits in the control unit beside the instruction decoder and the conditional-write logic. Driven by the instruction's Op/Funct fields, it steps each instruction through fetch, decode, execute, memory and writeback. Its per-state enables are the unconditioned requests: the conditional logic gates RegW, MemW, Branch and NextPC with the condition result before they reach architectural state.

## Interface
Parameters: none.
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  Instr[25:20]; bit 5 = immediate operand (I), bit 0 = load (L)
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- ALUSrcA  out  2  00 register A, 01 PC
- ALUSrcB  out  2  00 WriteData, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUOp  out  1  1 = decoder selects ALU function from Funct; 0 = add
- NextPC  out  1  request PC update to PC+4
- RegW  out  1  request register-file write
- MemW  out  1  request memory write
- Branch  out  1  request branch-target PC load

## Operation
Control vector order is NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp. Outputs depend only on current state.
- FETCH: 1,0,0,0,1,0,10,01,10,0 (IR<=Mem[PC], PC<=PC+4). Next state: DECODE.
- DECODE: 0,0,0,0,0,0,10,01,10,0 (PC+8 formed, register read). Next state by Op:
  - Op 00: Funct[5] ? EXECUTEI : EXECUTER
  - Op 01: MEMADR
  - Op 10: BRANCH
  - Op 11: UNKNOWN
- EXECUTER: 0,0,0,0,0,0,00,00,00,1. Next state: ALUWB.
- EXECUTEI: 0,0,0,0,0,0,00,00,01,1. Next state: ALUWB.
- ALUWB: 0,0,0,1,0,0,00,00,00,0. Next state: FETCH.
  - RegW is asserted even for compare ops; the decoder's NoWrite and the conditional logic suppress the write.
- MEMADR: 0,0,0,0,0,0,00,00,01,0. Next state: Funct[0] ? MEMRD : MEMWR.
- MEMRD: 0,0,0,0,0,1,00,00,00,0. Next state: MEMWB.
- MEMWB: 0,0,0,1,0,0,01,00,00,0. Next state: FETCH.
- MEMWR: 0,0,1,0,0,1,00,00,00,0. Next state: FETCH.
- BRANCH: 0,1,0,0,0,0,10,00,01,0. Next state: FETCH.
- UNKNOWN: all outputs 0, no architectural effect. Next state: FETCH.
- Any unencoded state register value: all outputs 0, next state FETCH.
- Op and Funct are sampled only in DECODE and MEMADR; their values in every other state are don't-care.

## Timing
- Reset: state = FETCH immediately, without waiting for a clock edge. Outputs show the FETCH vector during reset and after release.
- Reset mid-instruction aborts that instruction. At most the writes already committed on earlier edges stand.
- Latency, counted in cycles from FETCH to the next FETCH:
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - undefined: 3
- Exactly one of RegW, MemW, Branch and NextPC is high in any state, or none of them is.
- IRWrite is high only in FETCH.
- No handshake, no stalls: the memory has single-cycle access and the FSM never waits.

## Structure
- Shared package arm_multi_defs holds:
  - the 4-bit state encodings, in the order FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN=10
  - the ALUSrcA, ALUSrcB and ResultSrc encoding constants
- Single module with no sub-modules: a state register, a next-state case block and an output-decode case block producing the 13-bit control vector.

## Test plan
- Assert reset mid-MEMRD, release, then clock: state is FETCH (IRWrite=1, NextPC=1) during reset, with no clock edge needed; DECODE follows on the next edge.
- Op=00, Funct=6'b001000: states FETCH, DECODE, EXECUTER (ALUOp=1, ALUSrcB=00), ALUWB (RegW=1, ResultSrc=00), FETCH; 4 cycles.
- Op=00, Funct=6'b101001: the sequence uses EXECUTEI (ALUSrcB=01); 4 cycles.
- Op=01, Funct=6'b011001 (LDR): MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); 5 cycles.
- Op=01, Funct=6'b011000 (STR): MEMADR, MEMWR (MemW=1, AdrSrc=1); 4 cycles.
- Op=10 (B): BRANCH (Branch=1, ALUSrcA=00, ALUSrcB=01, ResultSrc=10); 3 cycles.
- Op=11: UNKNOWN with all outputs 0, then FETCH.
- On every cycle, check the enable exclusivity invariant.
